// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port and the decode-side handshake of the fetch unit.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        branch_enable;
    logic [31:0] branch_target;
    logic        fetch_fault;
    logic [31:0] inst_count;

    modport master (
        output imem_req, imem_addr, instruction, pc_out, inst_valid, fetch_fault, inst_count,
        input  imem_ready, imem_rdata, inst_ready, branch_enable, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, inst_valid, fetch_fault, inst_count,
        output imem_ready, imem_rdata, inst_ready, branch_enable, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: request a word, present it to decode,
// then follow sequential or relative-branch flow; a misaligned target locks up in FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        REQ   = 2'b00,
        HOLD  = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst_count;
    logic [31:0] w_next_pc;
    logic [31:0] w_target;
    logic        w_capture;
    logic        w_consume;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, capture/consume strobes and next fetch address
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_fetch_pc;
        w_capture    = 1'b0;
        w_consume    = 1'b0;
        w_target     = r_pc_out + bus.branch_target;
        case (r_state)
            REQ: begin
                if (bus.imem_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = HOLD;
                end else begin
                    w_next_state = REQ;
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    w_consume = 1'b1;
                    if (bus.branch_enable) begin
                        // Misaligned target is still latched so a debugger can see it
                        w_next_pc = w_target;
                        if (w_target[1:0] == 2'b00) begin
                            w_next_state = REQ;
                        end else begin
                            w_next_state = FAULT;
                        end
                    end else begin
                        w_next_pc    = r_pc_out + 32'd4;
                        w_next_state = REQ;
                    end
                end else begin
                    w_next_state = HOLD;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = FAULT;
            end
        endcase
    end

    // Fetch PC, presented instruction and consume counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_instruction <= 32'h0000_0000;
            r_pc_out      <= 32'h0000_0000;
            r_inst_count  <= 32'h0000_0000;
        end else begin
            if (w_capture) begin
                r_instruction <= bus.imem_rdata;
                r_pc_out      <= r_fetch_pc;
            end else begin
                r_instruction <= r_instruction;
                r_pc_out      <= r_pc_out;
            end
            if (w_consume) begin
                r_inst_count <= r_inst_count + 32'd1;
                r_fetch_pc   <= w_next_pc;
            end else begin
                r_inst_count <= r_inst_count;
                r_fetch_pc   <= r_fetch_pc;
            end
        end
    end

    // Request is masked by rst so nothing leaks to memory while reset is held
    assign bus.imem_req    = (r_state == REQ) && !rst;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instruction = r_instruction;
    assign bus.pc_out      = r_pc_out;
    assign bus.inst_valid  = (r_state == HOLD);
    assign bus.fetch_fault = (r_state == FAULT);
    assign bus.inst_count  = r_inst_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations for the reset, stall, branch, wrap and fault scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic data_mode;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic mode, input logic [31:0] a);
        return mode ? (a ^ 32'hDEAD_0000) : 32'h0000_0013;
    endfunction

    assign bus.imem_rdata = mem_word(data_mode, bus.imem_addr);

    int n_checks = 0;
    int n_errors = 0;

    // Model: next address to fetch, whether a word is being presented, and what it is
    logic [31:0] m_pc, m_inst, m_pcout, m_count;
    logic        m_presenting, m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_inst = 32'd0; m_pcout = 32'd0; m_count = 32'd0;
        m_presenting = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (rst) begin
            model_reset();
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (!m_presenting) begin
            if (bus.imem_ready) begin
                m_inst = mem_word(data_mode, m_pc);
                m_pcout = m_pc;
                m_presenting = 1'b1;
            end
        end else if (bus.inst_ready) begin
            m_count = m_count + 32'd1;
            m_presenting = 1'b0;
            t = bus.branch_enable ? (m_pcout + bus.branch_target) : (m_pcout + 32'd4);
            m_pc = t;
            if (bus.branch_enable && (t[1:0] != 2'b00)) m_fault = 1'b1;
        end
    endtask

    task automatic compare();
        logic exp_req, exp_valid;
        exp_req   = !rst && !m_fault && !m_presenting;
        exp_valid = !rst && !m_fault && m_presenting;
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
        check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_valid});
        if (exp_valid || rst) begin
            check("instruction", bus.instruction, m_inst);
            check("pc_out", bus.pc_out, m_pcout);
        end
        check("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
        check("inst_count", bus.inst_count, m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic rdy, input logic irdy, input logic be, input logic [31:0] bt);
        bus.imem_ready = rdy; bus.inst_ready = irdy;
        bus.branch_enable = be; bus.branch_target = bt;
    endtask

    logic [31:0] seen[$];
    int          valid_cnt;

    initial begin
        rst = 1'b1; data_mode = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        model_reset();
        #1 compare();
        tick(); tick();
        check("req_in_reset", {31'd0, bus.imem_req}, 32'd0);

        rst = 1'b0;
        #1;
        compare();
        check("req_after_reset", {31'd0, bus.imem_req}, 32'd1);
        check("addr_after_reset", bus.imem_addr, RPC);

        // Zero-wait streaming of 32'h13
        seen.push_back(bus.imem_addr);
        valid_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.imem_req) seen.push_back(bus.imem_addr);
            if (bus.inst_valid) valid_cnt++;
        end
        check("stream_addr0", seen[0], 32'h0);
        check("stream_addr1", seen[1], 32'h4);
        check("stream_addr2", seen[2], 32'h8);
        check("stream_valid_cnt", valid_cnt, 32'd3);
        check("stream_count", bus.inst_count, 32'd3);
        check("stream_inst", bus.instruction, 32'h0000_0013);

        // Memory stall: request held stable at 0xC
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_addr", bus.imem_addr, 32'hC);
            check("stall_req", {31'd0, bus.imem_req}, 32'd1);
            check("stall_valid", {31'd0, bus.inst_valid}, 32'd0);
        end

        // Decode stall, with branch inputs and imem_ready toggling that must be ignored
        data_mode = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_pc", bus.pc_out, 32'hC);
            check("hold_inst", bus.instruction, 32'hDEAD_000C);
            check("hold_req", {31'd0, bus.imem_req}, 32'd0);
            check("hold_count", bus.inst_count, 32'd3);
        end

        // Branch 0xC -> 0x100, then backward branch by -8 to 0xF8
        drive(1'b1, 1'b1, 1'b1, 32'h0000_00F4);
        tick();
        check("br_addr_100", bus.imem_addr, 32'h100);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        check("br_addr_f8", bus.imem_addr, 32'hF8);

        // Walk to 0xFC, branch to 0xFFFF_FFFC, then let sequential flow wrap to 0
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); tick(); tick();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FF00);
        tick();
        check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); tick();
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("wrap_count", bus.inst_count, 32'd8);

        // Reset while presenting 0x40
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        check("pre_rst_pc", bus.pc_out, 32'h40);
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc", bus.pc_out, 32'd0);
        check("rst_inst", bus.instruction, 32'd0);
        check("rst_count", bus.inst_count, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        compare();
        check("rerst_addr", bus.imem_addr, RPC);

        // Misaligned branch from 0x100 with offset 6
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        check("fault_setup_pc", bus.pc_out, 32'h100);
        drive(1'b1, 1'b1, 1'b1, 32'h6);
        tick();
        check("fault_flag", {31'd0, bus.fetch_fault}, 32'd1);
        check("fault_count", bus.inst_count, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fault_req", {31'd0, bus.imem_req}, 32'd0);
            check("fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
        end
        rst = 1'b1;
        model_reset();
        tick();
        check("fault_cleared", {31'd0, bus.fetch_fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
